// File: rtl/life_pkg.sv
// Shared types and constants for the life_grid Game of Life engine.
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_COMMIT = 2'd2
  } life_state_e;

  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;
  localparam logic [8:0] HIGHLIFE_BIRTH = 9'b001001000;

  // Wide enough to hold a neighbour count of 0..8.
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] count8(input logic [7:0] nb);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + CNT_W'(nb[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-generation evaluator for one grid row; the caller
// presents the rows above, at and below the row being computed.
module life_row_eval
  import life_pkg::*;
#(
  parameter int COLS = 8,
  parameter int WRAP = 0
) (
  input  logic [COLS-1:0] row_up,
  input  logic [COLS-1:0] row_cur,
  input  logic [COLS-1:0] row_dn,
  input  logic [8:0]      birth_mask,
  input  logic [8:0]      survive_mask,
  output logic [COLS-1:0] row_next
);

  logic [COLS-1:0] up_l_s, up_r_s, cur_l_s, cur_r_s, dn_l_s, dn_r_s;

  // Bit c of the result holds column c-1; column -1 is either dead or wraps.
  function automatic logic [COLS-1:0] from_left(input logic [COLS-1:0] v);
    if (WRAP != 0) begin
      return {v[COLS-2:0], v[COLS-1]};
    end else begin
      return {v[COLS-2:0], 1'b0};
    end
  endfunction

  function automatic logic [COLS-1:0] from_right(input logic [COLS-1:0] v);
    if (WRAP != 0) begin
      return {v[0], v[COLS-1:1]};
    end else begin
      return {1'b0, v[COLS-1:1]};
    end
  endfunction

  assign up_l_s  = from_left(row_up);
  assign up_r_s  = from_right(row_up);
  assign cur_l_s = from_left(row_cur);
  assign cur_r_s = from_right(row_cur);
  assign dn_l_s  = from_left(row_dn);
  assign dn_r_s  = from_right(row_dn);

  // Per-column neighbour count selects the rule bit for a live or dead cell.
  always_comb begin
    logic [CNT_W-1:0] cnt;
    row_next = '0;
    cnt      = '0;
    for (int c = 0; c < COLS; c++) begin
      cnt = count8({up_l_s[c], row_up[c], up_r_s[c], cur_l_s[c],
                    cur_r_s[c], dn_l_s[c], row_dn[c], dn_r_s[c]});
      if (row_cur[c]) begin
        row_next[c] = survive_mask[cnt];
      end else begin
        row_next[c] = birth_mask[cnt];
      end
    end
  end

endmodule

// File: rtl/life_grid.sv
// Row-serial Game of Life engine: one row evaluated per cycle, whole grid
// committed at once. Optional stable detection under LIFE_STABLE_DETECT_EN.
module life_grid
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8:0]               birth_mask,
  input  logic [8:0]               survive_mask,
  input  logic                     clear,
  input  logic                     load_valid,
  input  logic [$clog2(ROWS)-1:0]  load_row,
  input  logic [COLS-1:0]          load_data,
  output logic                     load_ready,
  input  logic                     step,
  input  logic                     run,
  output logic                     busy,
  output logic                     gen_done,
  output logic                     stable,
  output logic [GEN_W-1:0]         generation,
  output logic [ROWS*COLS-1:0]     grid
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  life_state_e            state_r;
  logic [RW-1:0]          row_r;
  logic [ROWS*COLS-1:0]   grid_r;
  logic [ROWS*COLS-1:0]   buf_r;
  logic [8:0]             birth_r, survive_r;
  logic [GEN_W-1:0]       generation_r;
  logic                   busy_r, gen_done_r, load_ready_r;

  int                     cur_i_s, up_i_s, dn_i_s;
  logic                   up_live_s, dn_live_s;
  logic [COLS-1:0]        row_up_s, row_cur_s, row_dn_s, row_next_s;
  logic                   idle_s, run_go_s;
  logic                   clear_go_s, load_go_s, start_go_s;

`ifdef LIFE_STABLE_DETECT_EN
  logic changed_r, stable_r;
  assign run_go_s = run & ~stable_r;
  assign stable   = stable_r;
`else
  assign run_go_s = run;
  assign stable   = 1'b0;
`endif

  assign idle_s     = (state_r == S_IDLE) & load_ready_r;
  assign clear_go_s = idle_s & clear;
  assign load_go_s  = idle_s & ~clear & load_valid & (int'(load_row) < ROWS);
  assign start_go_s = idle_s & ~clear & ~load_valid & (step | run_go_s);

  // Select the neighbour rows of the row under evaluation, honouring WRAP.
  always_comb begin
    cur_i_s   = int'(row_r);
    up_i_s    = 0;
    dn_i_s    = 0;
    up_live_s = 1'b1;
    dn_live_s = 1'b1;
    if (cur_i_s == 0) begin
      up_i_s    = ROWS - 1;
      up_live_s = (WRAP != 0);
    end else begin
      up_i_s    = cur_i_s - 1;
      up_live_s = 1'b1;
    end
    if (cur_i_s == ROWS - 1) begin
      dn_i_s    = 0;
      dn_live_s = (WRAP != 0);
    end else begin
      dn_i_s    = cur_i_s + 1;
      dn_live_s = 1'b1;
    end
    row_cur_s = grid_r[cur_i_s*COLS +: COLS];
    if (up_live_s) begin
      row_up_s = grid_r[up_i_s*COLS +: COLS];
    end else begin
      row_up_s = '0;
    end
    if (dn_live_s) begin
      row_dn_s = grid_r[dn_i_s*COLS +: COLS];
    end else begin
      row_dn_s = '0;
    end
  end

  life_row_eval #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row_eval (
    .row_up       (row_up_s),
    .row_cur      (row_cur_s),
    .row_dn       (row_dn_s),
    .birth_mask   (birth_r),
    .survive_mask (survive_r),
    .row_next     (row_next_s)
  );

  // Sequencer: IDLE loads/clears, EVAL fills the buffer, COMMIT publishes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      row_r        <= '0;
      grid_r       <= '0;
      buf_r        <= '0;
      birth_r      <= '0;
      survive_r    <= '0;
      generation_r <= '0;
      busy_r       <= 1'b0;
      gen_done_r   <= 1'b0;
      load_ready_r <= 1'b0;
    end else begin
      gen_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          load_ready_r <= 1'b1;
          if (clear_go_s) begin
            grid_r       <= '0;
            generation_r <= '0;
          end else if (load_go_s) begin
            grid_r[int'(load_row)*COLS +: COLS] <= load_data;
          end else if (start_go_s) begin
            state_r      <= S_EVAL;
            row_r        <= '0;
            birth_r      <= birth_mask;
            survive_r    <= survive_mask;
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_EVAL: begin
          buf_r[cur_i_s*COLS +: COLS] <= row_next_s;
          if (row_r == ROW_LAST) begin
            state_r <= S_COMMIT;
          end else begin
            row_r <= row_r + RW'(1);
          end
        end
        S_COMMIT: begin
          grid_r       <= buf_r;
          generation_r <= generation_r + GEN_W'(1);
          gen_done_r   <= 1'b1;
          busy_r       <= 1'b0;
          load_ready_r <= 1'b1;
          state_r      <= S_IDLE;
        end
        default: begin
          state_r      <= S_IDLE;
          busy_r       <= 1'b0;
          load_ready_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef LIFE_STABLE_DETECT_EN
  // Track whether any row changed during the step; any grid edit clears stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_r <= 1'b0;
      stable_r  <= 1'b0;
    end else if (clear_go_s || load_go_s) begin
      stable_r <= 1'b0;
    end else if (start_go_s) begin
      changed_r <= 1'b0;
    end else if (state_r == S_EVAL) begin
      changed_r <= changed_r | (|(row_next_s ^ row_cur_s));
    end else if (state_r == S_COMMIT) begin
      stable_r <= ~changed_r;
    end else begin
      changed_r <= changed_r;
    end
  end
`endif

  assign load_ready = load_ready_r;
  assign busy       = busy_r;
  assign gen_done   = gen_done_r;
  assign generation = generation_r;
  assign grid       = grid_r;

endmodule

// File: tb/tb_life_grid.sv
// Self-checking bench for life_grid: three instances (5x5 dead edges,
// 6x6 toroidal, 8x8 dead edges) checked against a neighbour-counting model.
module tb_life_grid;
  import life_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  birth_mask = CONWAY_BIRTH;
  logic [8:0]  survive_mask = CONWAY_SURVIVE;
  logic [2:0]  load_row = 3'd0;
  logic [7:0]  load_data = 8'd0;
  logic [2:0]  clear = 3'b000, load_valid = 3'b000, step = 3'b000, run = 3'b000;
  logic [2:0]  load_ready, busy, gen_done, stable;
  logic [15:0] gen5, gen6, gen8;
  logic [24:0] grid5;
  logic [35:0] grid6;
  logic [63:0] grid8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_grid #(.ROWS(5), .COLS(5), .WRAP(0), .GEN_W(16)) dut5 (
    .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .clear(clear[0]), .load_valid(load_valid[0]), .load_row(load_row),
    .load_data(load_data[4:0]), .load_ready(load_ready[0]), .step(step[0]),
    .run(run[0]), .busy(busy[0]), .gen_done(gen_done[0]), .stable(stable[0]),
    .generation(gen5), .grid(grid5));

  life_grid #(.ROWS(6), .COLS(6), .WRAP(1), .GEN_W(16)) dut6 (
    .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .clear(clear[1]), .load_valid(load_valid[1]), .load_row(load_row),
    .load_data(load_data[5:0]), .load_ready(load_ready[1]), .step(step[1]),
    .run(run[1]), .busy(busy[1]), .gen_done(gen_done[1]), .stable(stable[1]),
    .generation(gen6), .grid(grid6));

  life_grid #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut8 (
    .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .clear(clear[2]), .load_valid(load_valid[2]), .load_row(load_row),
    .load_data(load_data), .load_ready(load_ready[2]), .step(step[2]),
    .run(run[2]), .busy(busy[2]), .gen_done(gen_done[2]), .stable(stable[2]),
    .generation(gen8), .grid(grid8));

  function automatic int nsize(input int k);
    return (k == 0) ? 5 : ((k == 1) ? 6 : 8);
  endfunction

  function automatic int nwrap(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [63:0] cur_grid(input int k);
    if (k == 0) return {39'd0, grid5};
    else if (k == 1) return {28'd0, grid6};
    else return grid8;
  endfunction

  function automatic logic [15:0] cur_gen(input int k);
    if (k == 0) return gen5;
    else if (k == 1) return gen6;
    else return gen8;
  endfunction

  // Reference: count the eight neighbours of every cell directly.
  function automatic logic [63:0] life_next(input logic [63:0] g, input int n,
                                            input int w, input logic [8:0] b,
                                            input logic [8:0] s);
    logic [63:0] o;
    int cnt, rr, cc;
    o = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (w != 0) begin
              rr = (rr + n) % n;
              cc = (cc + n) % n;
            end else if (rr < 0 || rr >= n || cc < 0 || cc >= n) begin
              continue;
            end
            cnt += int'(g[rr*n+cc]);
          end
        end
        o[r*n+c] = g[r*n+c] ? s[cnt] : b[cnt];
      end
    end
    return o;
  endfunction

  function automatic logic [63:0] rand_grid(input int k);
    logic [63:0] g;
    int n;
    n = nsize(k);
    g = {$urandom(), $urandom()};
    if (n * n < 64) g &= (64'd1 << (n * n)) - 64'd1;
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_and_load(input int k, input logic [63:0] g);
    int n;
    logic [7:0] d;
    n = nsize(k);
    clear[k] = 1'b1;
    tick();
    clear[k] = 1'b0;
    for (int r = 0; r < n; r++) begin
      d = '0;
      for (int c = 0; c < n; c++) d[c] = g[r*n+c];
      load_row = 3'(r);
      load_data = d;
      load_valid[k] = 1'b1;
      tick();
      load_valid[k] = 1'b0;
    end
  endtask

  // Pulse step, then count edges until gen_done (bounded).
  task automatic do_step(input int k, output int lat, output logic bsy);
    step[k] = 1'b1;
    tick();
    step[k] = 1'b0;
    bsy = busy[k];
    lat = 1;
    while (!gen_done[k] && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (grid5 !== 25'd0 || grid6 !== 36'd0 || grid8 !== 64'd0) begin errors++; $display("FAIL reset_grid got %h %h %h exp 0", grid5, grid6, grid8); end
    checks++; if (gen5 !== 16'd0 || gen6 !== 16'd0 || gen8 !== 16'd0) begin errors++; $display("FAIL reset_gen got %0d %0d %0d exp 0", gen5, gen6, gen8); end
    checks++; if (busy !== 3'b000 || gen_done !== 3'b000 || stable !== 3'b000) begin errors++; $display("FAIL reset_flags busy %b done %b stable %b exp 000", busy, gen_done, stable); end
    rst = 1'b0;
    tick();
    checks++; if (load_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", load_ready); end
  endtask

  task automatic test_blinker();
    logic [63:0] g0, g1;
    int lat;
    logic bsy;
    g0 = '0; g0[11] = 1'b1; g0[12] = 1'b1; g0[13] = 1'b1;
    g1 = '0; g1[7] = 1'b1; g1[12] = 1'b1; g1[17] = 1'b1;
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(0, g0);
    checks++; if (cur_grid(0) !== g0) begin errors++; $display("FAIL load_visible got %h exp %h", cur_grid(0), g0); end
    for (int r = 5; r < 8; r++) begin
      load_row = 3'(r); load_data = 8'hFF; load_valid[0] = 1'b1; tick(); load_valid[0] = 1'b0;
    end
    checks++; if (cur_grid(0) !== g0) begin errors++; $display("FAIL load_oob got %h exp %h", cur_grid(0), g0); end
    do_step(0, lat, bsy);
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL blinker_busy got %b exp 1", bsy); end
    checks++; if (lat != 7) begin errors++; $display("FAIL blinker_latency got %0d exp 7", lat); end
    checks++; if (cur_grid(0) !== g1) begin errors++; $display("FAIL blinker_vert got %h exp %h", cur_grid(0), g1); end
    checks++; if (gen5 !== 16'd1 || busy[0] !== 1'b0) begin errors++; $display("FAIL blinker_gen got %0d busy %b exp 1 busy 0", gen5, busy[0]); end
    do_step(0, lat, bsy);
    checks++; if (cur_grid(0) !== g0 || gen5 !== 16'd2) begin errors++; $display("FAIL blinker_back got %h gen %0d exp %h gen 2", cur_grid(0), gen5, g0); end
  endtask

  task automatic test_glider();
    logic [63:0] g0, g;
    int cnt, cyc, first;
    g0 = '0; g0[1] = 1'b1; g0[8] = 1'b1; g0[12] = 1'b1; g0[13] = 1'b1; g0[14] = 1'b1;
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(1, g0);
    g = g0; cnt = 0; cyc = 0; first = 0;
    run[1] = 1'b1;
    while (cnt < 24 && cyc < 400) begin
      tick();
      cyc++;
      if (gen_done[1]) begin
        cnt++;
        if (cnt == 24) run[1] = 1'b0;
        g = life_next(g, 6, 1, CONWAY_BIRTH, CONWAY_SURVIVE);
        checks++; if (cur_grid(1) !== g) begin errors++; $display("FAIL glider_gen%0d got %h exp %h", cnt, cur_grid(1), g); end
        if (cnt == 1) first = cyc;
        if (cnt == 2) begin
          checks++; if (cyc - first != 8) begin errors++; $display("FAIL glider_period got %0d exp 8", cyc - first); end
        end
      end
    end
    run[1] = 1'b0;
    checks++; if (cur_grid(1) !== g0) begin errors++; $display("FAIL glider_home got %h exp %h", cur_grid(1), g0); end
    repeat (12) tick();
    checks++; if (gen6 !== 16'd24 || busy[1] !== 1'b0) begin errors++; $display("FAIL glider_count got %0d busy %b exp 24 busy 0", gen6, busy[1]); end
  endtask

  task automatic test_block();
    logic [63:0] g0, g1;
    int lat, cyc;
    logic bsy;
    g0 = '0; g0[0] = 1'b1; g0[1] = 1'b1; g0[8] = 1'b1; g0[9] = 1'b1;
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(2, g0);
    do_step(2, lat, bsy);
    checks++; if (grid8 !== g0 || gen8 !== 16'd1) begin errors++; $display("FAIL block_still got %h gen %0d exp %h gen 1", grid8, gen8, g0); end
`ifdef LIFE_STABLE_DETECT_EN
    checks++; if (stable[2] !== 1'b1) begin errors++; $display("FAIL block_stable got %b exp 1", stable[2]); end
    run[2] = 1'b1;
    repeat (30) tick();
    run[2] = 1'b0;
    checks++; if (gen8 !== 16'd1 || busy[2] !== 1'b0) begin errors++; $display("FAIL block_halt got %0d busy %b exp 1 busy 0", gen8, busy[2]); end
`else
    checks++; if (stable[2] !== 1'b0) begin errors++; $display("FAIL block_stable got %b exp 0", stable[2]); end
`endif
    load_row = 3'd5; load_data = 8'h38; load_valid[2] = 1'b1; tick(); load_valid[2] = 1'b0;
    g1 = g0 | (64'h38 << 40);
    checks++; if (stable[2] !== 1'b0 || grid8 !== g1) begin errors++; $display("FAIL block_load stable %b grid %h exp 0 %h", stable[2], grid8, g1); end
    run[2] = 1'b1;
    cyc = 0;
    while (!gen_done[2] && cyc < 40) begin tick(); cyc++; end
    run[2] = 1'b0;
    g1 = life_next(g1, 8, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
    checks++; if (gen8 !== 16'd2 || grid8 !== g1) begin errors++; $display("FAIL block_resume gen %0d grid %h exp 2 %h", gen8, grid8, g1); end
  endtask

  task automatic test_highlife();
    logic [63:0] g, six;
    int lat;
    logic bsy;
    g = '0;
    g[15:8] = 8'h38; g[23:16] = 8'h24; g[31:24] = 8'h22; g[39:32] = 8'h12; g[47:40] = 8'h0E;
    birth_mask = HIGHLIFE_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(2, g);
    for (int i = 1; i <= 4; i++) begin
      six = life_next(g, 8, 0, 9'b001000000, 9'b000000000);
      do_step(2, lat, bsy);
      g = life_next(g, 8, 0, HIGHLIFE_BIRTH, CONWAY_SURVIVE);
      checks++; if (grid8 !== g) begin errors++; $display("FAIL highlife_gen%0d got %h exp %h", i, grid8, g); end
      if (six != 64'd0) begin
        checks++; if ((grid8 & six) !== six) begin errors++; $display("FAIL highlife_six got %h exp %h", grid8 & six, six); end
      end
    end
  endtask

  task automatic test_eval_ignore();
    logic [63:0] g0, g1;
    logic [15:0] gen0;
    int lat;
    logic bad_rdy, bad_grid;
    g0 = rand_grid(2);
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(2, g0);
    gen0 = gen8;
    step[2] = 1'b1;
    tick();
    bad_rdy = 1'b0; bad_grid = 1'b0; lat = 1;
    clear[2] = 1'b1; load_valid[2] = 1'b1;
    while (!gen_done[2] && lat < 40) begin
      if (load_ready[2] !== 1'b0) bad_rdy = 1'b1;
      if (grid8 !== g0) bad_grid = 1'b1;
      birth_mask = 9'($urandom()); survive_mask = 9'($urandom());
      load_row = 3'($urandom()); load_data = 8'($urandom());
      tick();
      lat++;
    end
    step[2] = 1'b0; clear[2] = 1'b0; load_valid[2] = 1'b0;
    birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE;
    g1 = life_next(g0, 8, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
    checks++; if (bad_rdy !== 1'b0) begin errors++; $display("FAIL eval_ready got high exp low"); end
    checks++; if (bad_grid !== 1'b0) begin errors++; $display("FAIL eval_grid got changed exp %h", g0); end
    checks++; if (lat != 10) begin errors++; $display("FAIL eval_latency got %0d exp 10", lat); end
    checks++; if (grid8 !== g1) begin errors++; $display("FAIL eval_masklatch got %h exp %h", grid8, g1); end
    repeat (12) tick();
    checks++; if (gen8 !== gen0 + 16'd1 || busy[2] !== 1'b0) begin errors++; $display("FAIL eval_extra gen %0d busy %b exp %0d busy 0", gen8, busy[2], gen0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] g;
    int cnt, cyc, last;
    g = '0; g[1] = 1'b1; g[10] = 1'b1; g[16] = 1'b1; g[17] = 1'b1; g[18] = 1'b1;
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(2, g);
    cnt = 0; cyc = 0; last = 0;
    run[2] = 1'b1;
    while (cnt < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (gen_done[2]) begin
        cnt++;
        if (cnt == 3) run[2] = 1'b0;
        g = life_next(g, 8, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
        checks++; if (grid8 !== g) begin errors++; $display("FAIL b2b_gen%0d got %h exp %h", cnt, grid8, g); end
        if (cnt > 1) begin
          checks++; if (cyc - last != 10) begin errors++; $display("FAIL b2b_period got %0d exp 10", cyc - last); end
        end
        last = cyc;
      end
    end
    run[2] = 1'b0;
    checks++; if (gen8 !== 16'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", gen8); end
  endtask

  task automatic test_random();
    logic [63:0] g;
    logic [15:0] gen0;
    logic [8:0] b, s;
    int lat;
    logic bsy;
    for (int k = 1; k <= 2; k++) begin
      g = rand_grid(k);
      clear_and_load(k, g);
      for (int i = 0; i < 3; i++) begin
        b = 9'($urandom()); s = 9'($urandom());
        birth_mask = b; survive_mask = s;
        gen0 = cur_gen(k);
        do_step(k, lat, bsy);
        g = life_next(g, nsize(k), nwrap(k), b, s);
        checks++; if (cur_grid(k) !== g) begin errors++; $display("FAIL random_k%0d_%0d got %h exp %h", k, i, cur_grid(k), g); end
        checks++; if (cur_gen(k) !== gen0 + 16'd1) begin errors++; $display("FAIL random_gen_k%0d got %0d exp %0d", k, cur_gen(k), gen0 + 16'd1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    clear_and_load(2, rand_grid(2) | 64'h1);
    step[2] = 1'b1;
    tick();
    step[2] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (grid8 !== 64'd0 || gen8 !== 16'd0) begin errors++; $display("FAIL rstmid_state grid %h gen %0d exp 0 0", grid8, gen8); end
    checks++; if (busy[2] !== 1'b0 || gen_done[2] !== 1'b0 || stable[2] !== 1'b0) begin errors++; $display("FAIL rstmid_flags busy %b done %b stable %b exp 0", busy[2], gen_done[2], stable[2]); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (load_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b busy %b exp 1 0", load_ready[2], busy[2]); end
    repeat (12) tick();
    checks++; if (gen8 !== 16'd0 || grid8 !== 64'd0) begin errors++; $display("FAIL rstmid_after gen %0d grid %h exp 0 0", gen8, grid8); end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_glider();
    test_block();
    test_highlife();
    test_eval_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_grid.md
# life_grid

Row-serial Game of Life engine holding a parametrised ROWS×COLS generation in registers. Each step evaluates one row per cycle against a programmable birth/survive rule, then commits the whole new generation at once. Edges are either dead or toroidal. Sits between the pattern loader and the display scanner, replacing the per-cell array with a single sequenced block.

## Interface
- ROWS, 8: grid rows, ≥3.
- COLS, 8: grid columns, ≥3.
- WRAP, 0: 0 = out-of-grid neighbours are dead; 1 = toroidal wrap on both axes.
- GEN_W, 16: generation counter width.
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- birth_mask  in  9  bit n set → dead cell with n live neighbours is born.
- survive_mask  in  9  bit n set → live cell with n live neighbours survives.
- clear  in  1  zero the grid (IDLE only).
- load_valid  in  1  write load_data into row load_row.
- load_row  in  clog2(ROWS)  target row of a load.
- load_data  in  COLS  row contents; bit c = column c.
- load_ready  out  1  high in IDLE; loads are accepted only when high.
- step  in  1  request one generation.
- run  in  1  level; free-running generations while high.
- busy  out  1  evaluation in progress.
- gen_done  out  1  one-cycle pulse when a new generation becomes visible.
- stable  out  1  last committed generation equals its predecessor.
- generation  out  GEN_W  committed-generation count.
- grid  out  ROWS*COLS  current generation; bit r*COLS+c = cell (r,c).

## Operation
- FSM states: IDLE, EVAL, COMMIT.
- IDLE priority: clear > load_valid > (step | run).
  - clear zeroes grid and generation, and clears stable.
  - A load writes one row and clears stable; generation is unchanged.
  - load_row ≥ ROWS: load ignored.
- IDLE → EVAL on step, or on run with stable low. Start latches birth_mask/survive_mask; mid-step mask changes have no effect.
- EVAL: row counter 0..ROWS-1.
  - Row r is computed from current rows r-1, r, r+1 into a next-generation buffer.
  - Neighbour count n ∈ 0..8. Next cell = cur ? survive_mask[n] : birth_mask[n].
  - Edge handling per WRAP.
  - After row ROWS-1 → COMMIT.
- COMMIT: grid ← buffer, generation += 1 (wraps all-ones → 0), → IDLE.
- clear/load/step during EVAL or COMMIT are ignored. load_ready is low and nothing is queued.
- Rst at any time, including mid-EVAL: IDLE, grid = 0, buffer discarded, generation = 0, all outputs 0 except load_ready = 1 once Rst deasserts.

## Timing
- Cycle t: step or run sampled high in IDLE.
- Cycles t+1..t+ROWS: EVAL, busy = 1.
- Cycle t+ROWS+1: COMMIT, busy = 1.
- Cycle t+ROWS+2: new grid, generation and stable visible; gen_done = 1, busy = 0, state IDLE.
  - A step or run may be accepted in this same cycle, so the run-mode period is ROWS+2 cycles.
- Load visible on grid the cycle after acceptance.
- Reset values: busy 0, gen_done 0, stable 0, generation 0, grid 0.

## Configuration
- LIFE_STABLE_DETECT_EN defined:
  - A changed flag ORs per-row (new ≠ old) during EVAL.
  - At COMMIT, stable ← ~changed.
  - While stable = 1, run does not start new generations. An explicit step still executes.
- LIFE_STABLE_DETECT_EN undefined:
  - stable is tied 0 and run never self-halts.
  - No comparison logic is present.

## Structure
- Package life_pkg holds:
  - the state enum;
  - CONWAY_BIRTH = 9'b000001000 and CONWAY_SURVIVE = 9'b000001100;
  - HIGHLIFE_BIRTH = 9'b001001000;
  - the neighbour-count width constant.
- Sub-module life_row_eval: combinational. Inputs are three COLS-wide rows, the masks and WRAP; output is the next row. Instantiated once and time-multiplexed across rows.

## Test plan
- 5×5, WRAP=0, Conway: horizontal blinker in row 2, cols 1–3; step.
  - Expect vertical blinker (col 2, rows 1–3), gen_done at cycle t+7, generation = 1.
  - Second step restores the original pattern.
- 6×6, WRAP=1, Conway: glider, run held high.
  - After 24 generations the glider returns to its original pattern and position, shifted (6,6) ≡ (0,0).
  - generation = 24.
- WRAP=0: 2×2 block in corner (0,0); step → unchanged.
  - With LIFE_STABLE_DETECT_EN: stable = 1, run halts with generation = 1.
  - After a subsequent load, stable = 0 and run resumes.
- HighLife masks on a replicator seed; step.
  - Cells with 6 neighbours are born.
  - Compare against a reference model for 4 generations.
- Assert load_valid and step during EVAL; expect load_ready = 0, grid unaffected, no extra generation.
- Assert Rst at row 3 of EVAL on 8×8.
  - Expect grid = 0, generation = 0, busy = 0 immediately.
  - After deassertion, load_ready = 1.
